// File: rtl/decode_queue.sv
// Instruction queue with a combinational decoder on the head entry.
// Fetch pushes raw words; the consumer sees decoded fields of the oldest entry.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int IMM_W = 64,
    parameter int PC_W  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [10:0]      opcode,
    output logic [4:0]       rm,
    output logic [5:0]       shamt,
    output logic [4:0]       rn,
    output logic [4:0]       rt,
    output logic [18:0]      address,
    output logic [IMM_W-1:0] imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] dec_count,
    output logic [CNT_W-1:0] ill_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_D   = 3'd2,
        FMT_B   = 3'd3,
        FMT_CB  = 3'd4,
        FMT_ILL = 3'd7
    } fmt_e;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [PC_W-1:0] pc_mem_q    [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [CNT_W-1:0] dec_count_q, dec_count_d;
    logic [CNT_W-1:0] ill_count_q, ill_count_d;

    logic        push, pop;
    logic [31:0] head;
    fmt_e        fmt_c;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign head    = instr_mem_q[rd_ptr_q];
    assign out_pc  = pc_mem_q[rd_ptr_q];
    assign opcode  = head[31:21];
    assign rm      = head[20:16];
    assign shamt   = head[15:10];
    assign rn      = head[9:5];
    assign rt      = head[4:0];
    assign address = head[23:5];

    // Wider opcode classes are tested first so shorter prefixes win.
    always_comb begin
        fmt_c   = FMT_ILL;
        illegal = 1'b1;
        imm     = '0;
        if (head[31:26] == 6'b000101) begin
            fmt_c   = FMT_B;
            illegal = 1'b0;
            imm     = IMM_W'($signed(head[25:0]));
        end else if (head[31:24] inside {8'b10110100, 8'b10110101}) begin
            fmt_c   = FMT_CB;
            illegal = 1'b0;
            imm     = IMM_W'($signed(head[23:5]));
        end else if (head[31:22] inside {10'b1001000100, 10'b1011000100,
                                         10'b1101000100, 10'b1111000100}) begin
            fmt_c   = FMT_I;
            illegal = 1'b0;
            imm     = IMM_W'(head[21:10]);
        end else if (head[31:21] inside {11'b11111000000, 11'b11111000010}) begin
            fmt_c   = FMT_D;
            illegal = 1'b0;
            imm     = IMM_W'($signed(head[20:12]));
        end else if (head[31:21] inside {11'b10001011000, 11'b11001011000,
                                         11'b10101011000, 11'b11101011000,
                                         11'b10001010000, 11'b10101010000,
                                         11'b11010011011, 11'b11010011010}) begin
            fmt_c   = FMT_R;
            illegal = 1'b0;
            imm     = IMM_W'(head[15:10]);
        end
    end

    assign fmt = fmt_c;

    always_comb begin
        dec_count_d = dec_count_q;
        ill_count_d = ill_count_q;
        if (pop) begin
            if (dec_count_q != '1) dec_count_d = dec_count_q + CNT_W'(1);
            if (illegal && (ill_count_q != '1)) ill_count_d = ill_count_q + CNT_W'(1);
        end
    end

    assign dec_count = dec_count_q;
    assign ill_count = ill_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dec_count_q <= '0;
            ill_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dec_count_q <= dec_count_d;
            ill_count_q <= ill_count_d;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode vector table plus queue corner sequences.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [10:0] opcode;
    logic [4:0]  rm;
    logic [5:0]  shamt;
    logic [4:0]  rn;
    logic [4:0]  rt;
    logic [18:0] address;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
    logic [15:0] dec_count;
    logic [15:0] ill_count;

    decode_queue dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rm(rm), .shamt(shamt), .rn(rn), .rt(rt), .address(address),
        .imm(imm), .fmt(fmt), .illegal(illegal),
        .dec_count(dec_count), .ill_count(ill_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
        logic [4:0]  rn;
        logic [4:0]  rt;
    } vec_t;

    localparam int NV = 11;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    vec_t vecs [NV];
    int   checks = 0;
    int   failures = 0;
    int   exp_dec = 0;
    int   exp_ill = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'hB4038226, 3'd4, 64'h1C11, 1'b0, 5'd17, 5'd6};
        vecs[1]  = '{32'hB1002020, 3'd1, 64'd8,    1'b0, 5'd1,  5'd0};
        vecs[2]  = '{32'hF8420020, 3'd2, 64'd32,   1'b0, 5'd1,  5'd0};
        vecs[3]  = '{32'h14000002, 3'd3, 64'd2,    1'b0, 5'd0,  5'd2};
        vecs[4]  = '{32'h00000000, 3'd7, 64'd0,    1'b1, 5'd0,  5'd0};
        vecs[5]  = '{32'h17FFFFFF, 3'd3, ONES,     1'b0, 5'd31, 5'd31};
        vecs[6]  = '{32'hB4FFFFE0, 3'd4, ONES,     1'b0, 5'd31, 5'd0};
        vecs[7]  = '{32'hD3600C41, 3'd0, 64'd3,    1'b0, 5'd2,  5'd1};
        vecs[8]  = '{32'hF85FF020, 3'd2, ONES,     1'b0, 5'd1,  5'd0};
        vecs[9]  = '{32'h913FFC00, 3'd1, 64'hFFF,  1'b0, 5'd0,  5'd0};
        vecs[10] = '{32'hFFFFFFFF, 3'd7, 64'd0,    1'b1, 5'd31, 5'd31};

        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dec", dec_count, 0);
        chk("rst_ill", ill_count, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        // Decode table: each word pushed into an empty queue, checked, popped.
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 64'h1000 + 64'(i * 4);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_fmt", i), fmt, vecs[i].fmt);
            chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("v%0d_ill", i), illegal, vecs[i].ill);
            chk($sformatf("v%0d_rn", i), rn, vecs[i].rn);
            chk($sformatf("v%0d_rt", i), rt, vecs[i].rt);
            chk($sformatf("v%0d_pc", i), out_pc, 64'h1000 + 64'(i * 4));
            if (vecs[i].instr == 32'hB4038226) begin
                chk("cbz_opcode", opcode, 11'h5A0);
                chk("cbz_rm", rm, 5'd3);
                chk("cbz_shamt", shamt, 6'd32);
                chk("cbz_address", address, 19'h01C11);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            exp_dec++;
            if (vecs[i].ill) exp_ill++;
            chk($sformatf("v%0d_empty", i), out_valid, 0);
            chk($sformatf("v%0d_dec", i), dec_count, 64'(exp_dec));
            chk($sformatf("v%0d_illcnt", i), ill_count, 64'(exp_ill));
        end

        // Back-to-back stream with the consumer always ready.
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hB1002020; in_pc = 64'h2000;
        tick();
        in_instr = 32'hF8420020; in_pc = 64'h2004;
        chk("s0_fmt", fmt, 1); chk("s0_imm", imm, 8); chk("s0_rn", rn, 1); chk("s0_rt", rt, 0);
        tick();
        in_instr = 32'h14000002; in_pc = 64'h2008;
        chk("s1_fmt", fmt, 2); chk("s1_imm", imm, 32); chk("s1_rn", rn, 1);
        chk("s1_pc", out_pc, 64'h2004);
        tick();
        in_valid = 1'b0;
        chk("s2_fmt", fmt, 3); chk("s2_imm", imm, 2); chk("s2_pc", out_pc, 64'h2008);
        tick();
        out_ready = 1'b0;
        exp_dec += 3;
        chk("s_empty", out_valid, 0);
        chk("s_dec", dec_count, 64'(exp_dec));

        // Fill to full, fifth word held until a pop frees a slot.
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("f%0d_ready", k), in_ready, 1);
            in_valid = 1'b1; in_instr = 32'h14000000 + 32'(k); in_pc = 64'h200 + 64'(k);
            tick();
        end
        chk("full_ready", in_ready, 0);
        in_instr = 32'h14000004; in_pc = 64'h204;
        tick();
        chk("full_held", in_ready, 0);
        chk("full_head", out_pc, 64'h200);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_dec++;
        chk("freed_ready", in_ready, 1);
        chk("freed_head", out_pc, 64'h201);
        tick();
        in_valid = 1'b0;
        chk("refull_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("drain%0d_valid", k), out_valid, 1);
            chk($sformatf("drain%0d_pc", k), out_pc, 64'h200 + 64'(k));
            tick();
            exp_dec++;
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("drain_dec", dec_count, 64'(exp_dec));

        // Flush with three entries and a simultaneous incoming word.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = 32'h14000010; in_pc = 64'h300 + 64'(k);
            tick();
        end
        flush = 1'b1; in_instr = 32'hDEADBEEF; in_pc = 64'h3FF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        chk("flush_dec", dec_count, 64'(exp_dec));
        chk("flush_ill", ill_count, 64'(exp_ill));
        tick();
        chk("flush_absent", out_valid, 0);
        in_valid = 1'b1; in_instr = 32'h14000002; in_pc = 64'h310;
        tick();
        in_valid = 1'b0;
        chk("postflush_pc", out_pc, 64'h310);

        // Asynchronous reset with entries queued.
        in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 64'h320;
        tick();
        in_valid = 1'b0;
        chk("prereset_count", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_dec", dec_count, 0);
        chk("arst_ill", ill_count, 0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1; in_instr = 32'hB4038226; in_pc = 64'h400;
        tick();
        in_valid = 1'b0;
        chk("rel_valid", out_valid, 1);
        chk("rel_pc", out_pc, 64'h400);
        chk("rel_fmt", fmt, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_dec", dec_count, 1);
        chk("rel_empty", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
